push_it: RTL and testbench

//  Event packer for the time-counter board. Captures trigger and cycle events
//  (event number plus 36-bit timestamp) in the fast clock domain.

---
 rtl/push_it_pkg.sv | 28 ++
 rtl/push_it_slow_tick.sv | 35 +++
 rtl/push_it.sv | 121 ++++++++++++
 tb/tb_push_it.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/push_it_pkg.sv
// ============================================================================
// Module   : push_it_pkg
// Brief    : Shared record layout constants and FSM state type for push_it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package push_it_pkg;

    localparam logic [1:0] REC_TRIG  = 2'b01;
    localparam logic [1:0] REC_CYCLE = 2'b10;
    localparam int         REC_BYTES = 7;
    localparam int         NUM_W     = 18;
    localparam int         TIME_W    = 36;
    localparam int         REC_W     = 2 + NUM_W + TIME_W;
    localparam int         IDX_W     = 3;

    // Byte index value reached once the last byte of a record has gone out
    localparam logic [IDX_W-1:0] REC_DONE = IDX_W'(REC_BYTES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/push_it_slow_tick.sv
// ============================================================================
// Module   : slow_tick
// Brief    : Synchronises the slow clock level and pulses tick on its rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slow_tick #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clkslow,
    output logic tick
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Tick is registered, so it lands SYNC_STAGES+1 clocks after the slow rise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            tick   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clkslow};
            r_prev <= r_sync[SYNC_STAGES-1];
            tick   <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

endmodule

`default_nettype wire

// File: rtl/push_it.sv
// ============================================================================
// Module   : push_it
// Brief    : Captures trigger/cycle events and serialises them as 7-byte records.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module push_it
    import push_it_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clkslow,
    input  logic              trigready,
    input  logic              cycleready,
    input  logic [NUM_W-1:0]  trignum,
    input  logic [NUM_W-1:0]  cyclenum,
    input  logic [TIME_W-1:0] timenum,
    input  logic              busy,
    output logic [7:0]        data,
    output logic              write
);

    logic              w_tick;

    logic [NUM_W-1:0]  r_trig_num;
    logic [TIME_W-1:0] r_trig_time;
    logic              r_trig_pend;
    logic [NUM_W-1:0]  r_cycle_num;
    logic [TIME_W-1:0] r_cycle_time;
    logic              r_cycle_pend;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [REC_W-1:0]  r_rec;
    logic              r_rec_is_trig;

    slow_tick #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_slow_tick (
        .clk     (clk),
        .reset   (reset),
        .clkslow (clkslow),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_trig_num    <= '0;
            r_trig_time   <= '0;
            r_trig_pend   <= 1'b0;
            r_cycle_num   <= '0;
            r_cycle_time  <= '0;
            r_cycle_pend  <= 1'b0;
            r_state       <= IDLE;
            r_idx         <= '0;
            r_rec         <= '0;
            r_rec_is_trig <= 1'b0;
            data          <= 8'h00;
            write         <= 1'b0;
        end else begin
            // A pending flag stays set until its record is fully sent, so it
            // also blocks new captures while that record is on the wire.
            if (trigready && !r_trig_pend) begin
                r_trig_pend <= 1'b1;
                r_trig_num  <= trignum;
                r_trig_time <= timenum;
            end
            if (cycleready && !r_cycle_pend) begin
                r_cycle_pend <= 1'b1;
                r_cycle_num  <= cyclenum;
                r_cycle_time <= timenum;
            end

            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        write <= 1'b0;
                        r_idx <= '0;
                        if (r_trig_pend) begin
                            r_rec         <= {REC_TRIG, r_trig_num, r_trig_time};
                            r_rec_is_trig <= 1'b1;
                            r_state       <= SEND;
                        end else if (r_cycle_pend) begin
                            r_rec         <= {REC_CYCLE, r_cycle_num, r_cycle_time};
                            r_rec_is_trig <= 1'b0;
                            r_state       <= SEND;
                        end
                    end
                    SEND: begin
                        if (r_idx == REC_DONE) begin
                            write   <= 1'b0;
                            r_state <= IDLE;
                            if (r_rec_is_trig) begin
                                r_trig_pend <= 1'b0;
                            end else begin
                                r_cycle_pend <= 1'b0;
                            end
                        end else if (busy) begin
                            write <= 1'b0;
                        end else begin
                            data  <= r_rec[REC_W-1 -: 8];
                            r_rec <= {r_rec[REC_W-9:0], 8'h00};
                            write <= 1'b1;
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    default: begin
                        write   <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_push_it.sv
// ============================================================================
// Module   : tb_push_it
// Brief    : Scoreboard bench for push_it; bytes are sampled as a clkslow FIFO would.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_push_it;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clkslow = 1'b0;
    logic        trigready = 1'b0;
    logic        cycleready = 1'b0;
    logic [17:0] trignum = '0;
    logic [17:0] cyclenum = '0;
    logic [35:0] timenum = '0;
    logic        busy = 1'b0;
    logic [7:0]  data;
    logic        write;

    int          checks = 0;
    int          errors = 0;
    int          rx_count = 0;
    logic [7:0]  exp_q[$];

    push_it #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .clkslow    (clkslow),
        .trigready  (trigready),
        .cycleready (cycleready),
        .trignum    (trignum),
        .cyclenum   (cyclenum),
        .timenum    (timenum),
        .busy       (busy),
        .data       (data),
        .write      (write)
    );

    always #3 clk = ~clk;

    // Slow clock edges sit between fast clock edges
    initial begin
        #1;
        forever #12 clkslow = ~clkslow;
    end

    // Monitor: a downstream FIFO clocked mid-period by clkslow
    always @(negedge clkslow) begin
        if (!reset && write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got data=%02h, expected no write", data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    errors++;
                    $display("FAIL byte%0d: got %02h, expected %02h", rx_count, data, e);
                end
            end
            rx_count++;
        end
    end

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %03h, expected %03h", name, got, exp);
        end
    endtask

    task automatic push_rec(input logic [55:0] rec);
        for (int i = 0; i < 7; i++) exp_q.push_back(rec[55-8*i -: 8]);
    endtask

    task automatic slow_period();
        @(negedge clkslow);
        #1;
    endtask

    task automatic pulse(input logic t, input logic c);
        @(negedge clk);
        trigready  = t;
        cycleready = c;
        @(negedge clk);
        trigready  = 1'b0;
        cycleready = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_periods);
        for (int i = 0; i < max_periods && exp_q.size() != 0; i++) slow_period();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d bytes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_rx(input string name, input int target, input int max_periods);
        for (int i = 0; i < max_periods && rx_count < target; i++) slow_period();
        checks++;
        if (rx_count < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d bytes, expected %0d", name, rx_count, target);
        end
    endtask

    initial begin
        // 1: reset held for three slow periods, then quiet with no events
        for (int i = 0; i < 3; i++) begin
            slow_period();
            check("reset_out", {write, data}, 9'h000);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            slow_period();
            check("idle_write", {8'h00, write}, 9'h000);
        end
        check("idle_data", {1'b0, data}, 9'h000);

        // 2: single trigger record
        trignum = 18'h12345;
        timenum = 36'h123456789;
        push_rec(56'h52345123456789);
        pulse(1'b1, 1'b0);
        wait_drain("trig", 20);
        slow_period();
        check("trig_after", {write, data}, 9'h089);

        // 3: single cycle record, issued about 500 ns later
        repeat (84) @(negedge clk);
        cyclenum = 18'h26789;
        push_rec(56'hA6789123456789);
        pulse(1'b0, 1'b1);
        wait_drain("cycle", 20);
        slow_period();
        check("cycle_after", {8'h00, write}, 9'h000);

        // 4: both events in the same clock; trigger goes first, same timestamp
        trignum  = 18'h3FFFF;
        cyclenum = 18'h00001;
        timenum  = 36'hFEDCBA987;
        push_rec(56'h7FFFFFEDCBA987);
        push_rec(56'h80001FEDCBA987);
        pulse(1'b1, 1'b1);
        timenum = 36'h000000000;
        wait_drain("both", 40);
        slow_period();
        check("both_after", {8'h00, write}, 9'h000);

        // 5: busy for three ticks while byte 3 is due
        trignum = 18'h0ABCD;
        timenum = 36'h000000001;
        push_rec(56'h4ABCD000000001);
        pulse(1'b1, 1'b0);
        wait_rx("busy_pre", rx_count + 3, 20);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slow_period();
            check("busy_hold", {8'h00, write}, 9'h000);
        end
        busy = 1'b0;
        wait_drain("busy", 20);

        // 6: second trigger during a trigger record is dropped
        slow_period();
        slow_period();
        trignum = 18'h00F0F;
        timenum = 36'hABCDEF012;
        push_rec(56'h40F0FABCDEF012);
        pulse(1'b1, 1'b0);
        wait_rx("drop_pre", rx_count + 2, 20);
        trignum = 18'h11111;
        timenum = 36'h999999999;
        pulse(1'b1, 1'b0);
        wait_drain("drop", 20);
        for (int i = 0; i < 6; i++) begin
            slow_period();
            check("drop_quiet", {8'h00, write}, 9'h000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
